// File: rtl/sfo_search_controller_pkg.sv
// sfo_search_controller_pkg: shared SFO/correlator widths, fractional range and FSM state encoding.
package sfo_search_controller_pkg;
  localparam int SFO_INT_WIDTH = 8;
  localparam int SFO_FRAC_WIDTH = 10;
  localparam int SFO_FRAC_RANGE = 1000;
  localparam int CORR_MANTISSA_WIDTH = 16;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4,
    S_CMP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;
endpackage

// File: rtl/sfo_search_controller_stepper.sv
// sfo_hyp_stepper: int/frac SFO hypothesis accumulator; frac wraps at SFO_FRAC_RANGE and carries into int.
module sfo_hyp_stepper
  import sfo_search_controller_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      load,
  input  logic                      advance,
  input  logic [SFO_INT_WIDTH-1:0]  start_int,
  input  logic [SFO_FRAC_WIDTH-1:0] start_frac,
  input  logic [SFO_INT_WIDTH-1:0]  step_int,
  input  logic [SFO_FRAC_WIDTH-1:0] step_frac,
  output logic [SFO_INT_WIDTH-1:0]  sfo_int,
  output logic [SFO_FRAC_WIDTH-1:0] sfo_frac
);
  localparam logic [SFO_FRAC_WIDTH:0] RANGE_X = (SFO_FRAC_WIDTH+1)'(SFO_FRAC_RANGE);
  logic [SFO_INT_WIDTH-1:0] inc_int;
  logic [SFO_FRAC_WIDTH-1:0] inc_frac, frac_next;
  logic [SFO_FRAC_WIDTH:0] frac_sum, frac_wrap;
  logic carry;
  always_comb begin
    frac_sum = {1'b0, sfo_frac} + {1'b0, inc_frac};
    frac_wrap = frac_sum - RANGE_X;
    carry = frac_sum >= RANGE_X;
    frac_next = carry ? frac_wrap[SFO_FRAC_WIDTH-1:0] : frac_sum[SFO_FRAC_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sfo_int <= '0;
      sfo_frac <= '0;
      inc_int <= '0;
      inc_frac <= '0;
    end else if (load) begin
      sfo_int <= start_int;
      sfo_frac <= start_frac;
      inc_int <= step_int;
      inc_frac <= step_frac;
    end else if (advance) begin
      sfo_int <= sfo_int + inc_int + SFO_INT_WIDTH'(carry);
      sfo_frac <= frac_next;
    end
endmodule

// File: rtl/sfo_search_controller.sv
// sfo_search_controller: sweeps SFO hypotheses through one correlator, replaying the FFT buffer and tracking the arg-max.
// Define SFO_SEARCH_TIMEOUT_EN to add a WAIT watchdog that skips hypotheses whose result never arrives.
module sfo_search_controller
  import sfo_search_controller_pkg::*;
#(
  parameter int FFT_LEN_LOG2 = 9,
  parameter int POWER_WIDTH = 16,
  parameter int NUM_HYP_LOG2 = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_HYP_LOG2-1:0]        num_hyp,
  input  logic [SFO_INT_WIDTH-1:0]       sfo_start_int,
  input  logic [SFO_FRAC_WIDTH-1:0]      sfo_start_frac,
  input  logic [SFO_INT_WIDTH-1:0]       sfo_step_int,
  input  logic [SFO_FRAC_WIDTH-1:0]      sfo_step_frac,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout_err,
  output logic                           mem_rd_en,
  output logic [FFT_LEN_LOG2-1:0]        mem_rd_addr,
  input  logic [POWER_WIDTH-1:0]         mem_rd_data,
  output logic [SFO_INT_WIDTH-1:0]       corr_sfo_int_part,
  output logic [SFO_FRAC_WIDTH-1:0]      corr_sfo_frac_part,
  output logic                           corr_reset,
  output logic                           corr_update,
  output logic [POWER_WIDTH-1:0]         corr_fft_mag,
  input  logic [CORR_MANTISSA_WIDTH-1:0] corr_out,
  input  logic                           corr_out_valid,
  output logic [SFO_INT_WIDTH-1:0]       best_sfo_int,
  output logic [SFO_FRAC_WIDTH-1:0]      best_sfo_frac,
  output logic [CORR_MANTISSA_WIDTH-1:0] best_corr,
  output logic [NUM_HYP_LOG2-1:0]        best_index,
  output logic                           result_valid
);
  state_t state;
  logic [NUM_HYP_LOG2-1:0] idx, num_q;
  logic have_best, last, wait_to;
  assign corr_fft_mag = mem_rd_data;
  assign last = idx == num_q - NUM_HYP_LOG2'(1);
  sfo_hyp_stepper u_stepper (
    .clk(clk),
    .resetn(resetn),
    .load(state == S_IDLE && start),
    .advance(state == S_CMP || wait_to),
    .start_int(sfo_start_int),
    .start_frac(sfo_start_frac),
    .step_int(sfo_step_int),
    .step_frac(sfo_step_frac),
    .sfo_int(corr_sfo_int_part),
    .sfo_frac(corr_sfo_frac_part)
  );
`ifdef SFO_SEARCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic timeout_q;
  assign wait_to = state == S_WAIT && !corr_out_valid && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_err = timeout_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wait_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= state == S_WAIT ? wait_cnt + TW'(1) : '0;
      if (state == S_IDLE && start) timeout_q <= 1'b0;
      else if (wait_to && !abort) timeout_q <= 1'b1;
    end
`else
  assign wait_to = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // Outputs are registered on entry to the state they belong to, so they line up with that state's cycle.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      corr_reset <= 1'b0;
      corr_update <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_rd_addr <= '0;
      idx <= '0;
      num_q <= '0;
      have_best <= 1'b0;
      result_valid <= 1'b0;
      best_sfo_int <= '0;
      best_sfo_frac <= '0;
      best_corr <= '0;
      best_index <= '0;
    end else begin
      corr_update <= mem_rd_en;
      corr_reset <= 1'b0;
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy <= 1'b0;
        mem_rd_en <= 1'b0;
        corr_reset <= 1'b1;
      end else case (state)
        S_IDLE: if (start) begin
          num_q <= num_hyp;
          idx <= '0;
          have_best <= 1'b0;
          result_valid <= 1'b0;
          busy <= 1'b1;
          state <= num_hyp == '0 ? S_DONE : S_LOAD;
          done <= num_hyp == '0;
          corr_reset <= num_hyp != '0;
        end
        S_LOAD: begin
          state <= S_STREAM;
          mem_rd_en <= 1'b1;
          mem_rd_addr <= '0;
        end
        S_STREAM: if (mem_rd_addr == '1) begin
          state <= S_DRAIN;
          mem_rd_en <= 1'b0;
        end else mem_rd_addr <= mem_rd_addr + FFT_LEN_LOG2'(1);
        S_DRAIN: state <= S_WAIT;
        S_WAIT: if (corr_out_valid) state <= S_CMP;
        else if (wait_to) begin
          idx <= idx + NUM_HYP_LOG2'(1);
          state <= last ? S_DONE : S_LOAD;
          done <= last;
          corr_reset <= !last;
          result_valid <= last && have_best;
        end
        S_CMP: begin
          if (!have_best || corr_out > best_corr) begin
            have_best <= 1'b1;
            best_corr <= corr_out;
            best_index <= idx;
            best_sfo_int <= corr_sfo_int_part;
            best_sfo_frac <= corr_sfo_frac_part;
          end
          idx <= idx + NUM_HYP_LOG2'(1);
          state <= last ? S_DONE : S_LOAD;
          done <= last;
          corr_reset <= !last;
          result_valid <= last;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_sfo_search_controller.sv
// tb_sfo_search_controller: directed sweeps against a buffer model and a behavioural correlator.
module tb_sfo_search_controller;
  import sfo_search_controller_pkg::*;
  localparam int FL = 3, PW = 16, NL = 8, LAT = 5, R = SFO_FRAC_RANGE;
  logic clk = 1'b0;
  logic resetn, start, abort;
  logic [NL-1:0] num_hyp;
  logic [SFO_INT_WIDTH-1:0] s_int, t_int, corr_sfo_int_part, best_sfo_int;
  logic [SFO_FRAC_WIDTH-1:0] s_frac, t_frac, corr_sfo_frac_part, best_sfo_frac;
  logic busy, done, timeout_err, mem_rd_en, corr_reset, corr_update, corr_out_valid, result_valid;
  logic [FL-1:0] mem_rd_addr;
  logic [PW-1:0] mem_rd_data, corr_fft_mag;
  logic [CORR_MANTISSA_WIDTH-1:0] corr_out, best_corr;
  logic [NL-1:0] best_index;
  logic [PW-1:0] bufm [8];
  logic [CORR_MANTISSA_WIDTH-1:0] corr_vals [16];
  logic [15:0] hang_mask = '0;
  logic [SFO_INT_WIDTH-1:0] seen_int [16];
  logic [SFO_FRAC_WIDTH-1:0] seen_frac [16];
  int rst_cnt = 0, base = 0, hyp_k, ucnt, rd_cnt, lat;
  int upd_total = 0, stream_err = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  sfo_search_controller #(.FFT_LEN_LOG2(FL), .POWER_WIDTH(PW), .NUM_HYP_LOG2(NL), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .num_hyp(num_hyp),
    .sfo_start_int(s_int), .sfo_start_frac(s_frac), .sfo_step_int(t_int), .sfo_step_frac(t_frac),
    .busy(busy), .done(done), .timeout_err(timeout_err), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .corr_sfo_int_part(corr_sfo_int_part), .corr_sfo_frac_part(corr_sfo_frac_part),
    .corr_reset(corr_reset), .corr_update(corr_update), .corr_fft_mag(corr_fft_mag), .corr_out(corr_out),
    .corr_out_valid(corr_out_valid), .best_sfo_int(best_sfo_int), .best_sfo_frac(best_sfo_frac),
    .best_corr(best_corr), .best_index(best_index), .result_valid(result_valid)
  );
  assign hyp_k = rst_cnt - base - 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= bufm[mem_rd_addr];
  always @(posedge clk) if (resetn && corr_reset && busy) begin
    if (rst_cnt - base < 16) begin
      seen_int[rst_cnt - base] <= corr_sfo_int_part;
      seen_frac[rst_cnt - base] <= corr_sfo_frac_part;
    end
    rst_cnt <= rst_cnt + 1;
  end
  // Correlator model: result appears LAT cycles into WAIT, cleared by corr_reset.
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      corr_out_valid <= 1'b0;
      corr_out <= '0;
      ucnt <= 0;
      rd_cnt <= 0;
      lat <= 0;
    end else if (corr_reset) begin
      corr_out_valid <= 1'b0;
      ucnt <= 0;
      rd_cnt <= 0;
      lat <= 0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_cnt > 7 || int'(mem_rd_addr) != rd_cnt) stream_err <= stream_err + 1;
      end
      if (corr_update) begin
        ucnt <= ucnt + 1;
        upd_total <= upd_total + 1;
        if (ucnt > 7 || corr_fft_mag != bufm[ucnt[2:0]]) stream_err <= stream_err + 1;
      end
      if (ucnt == 8 && !corr_out_valid && !hang_mask[hyp_k[3:0]]) begin
        lat <= lat + 1;
        if (lat == LAT - 2) begin
          corr_out_valid <= 1'b1;
          corr_out <= corr_vals[hyp_k[3:0]];
        end
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic sweep(input int n, input int si, input int sf, input int ti, input int tf,
                       input int budget, output int cyc, output bit ok);
    base = rst_cnt;
    num_hyp = NL'(n);
    s_int = SFO_INT_WIDTH'(si);
    s_frac = SFO_FRAC_WIDTH'(sf);
    t_int = SFO_INT_WIDTH'(ti);
    t_frac = SFO_FRAC_WIDTH'(tf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    ok = done;
  endtask
  initial begin
    int cyc, u0;
    bit ok, saw_done;
    for (int i = 0; i < 8; i++) bufm[i] = PW'(16'h1000 + i * 16'h0111);
    for (int i = 0; i < 16; i++) corr_vals[i] = '0;
    resetn = 1'b0; start = 1'b0; abort = 1'b0; num_hyp = '0;
    s_int = '0; s_frac = '0; t_int = '0; t_frac = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_rden", mem_rd_en, 0);
    chk("rst_best", best_corr, 0);
    resetn = 1'b1;
    @(negedge clk);
    // single hypothesis
    corr_vals[0] = 16'h0123;
    u0 = upd_total;
    sweep(1, 4, 0, 0, 0, 100, cyc, ok);
    chk("t1_done", ok, 1);
    chk("t1_cycles", cyc, 17);
    chk("t1_updates", upd_total - u0, 8);
    chk("t1_stream", stream_err, 0);
    chk("t1_index", best_index, 0);
    chk("t1_corr", best_corr, 16'h0123);
    chk("t1_int", best_sfo_int, 4);
    chk("t1_rv", result_valid, 1);
    @(negedge clk);
    chk("t1_pulse", done, 0);
    chk("t1_idle", busy, 0);
    // four hypotheses with a tie, started back to back
    corr_vals[0] = 10; corr_vals[1] = 30; corr_vals[2] = 30; corr_vals[3] = 20;
    sweep(4, 3, R / 2, 2, R / 2, 200, cyc, ok);
    chk("t2_done", ok, 1);
    chk("t2_cycles", cyc, 65);
    chk("t2_h0i", seen_int[0], 3);  chk("t2_h0f", seen_frac[0], R / 2);
    chk("t2_h1i", seen_int[1], 6);  chk("t2_h1f", seen_frac[1], 0);
    chk("t2_h2i", seen_int[2], 8);  chk("t2_h2f", seen_frac[2], R / 2);
    chk("t2_h3i", seen_int[3], 11); chk("t2_h3f", seen_frac[3], 0);
    chk("t2_index", best_index, 1);
    chk("t2_int", best_sfo_int, 6);
    chk("t2_frac", best_sfo_frac, 0);
    chk("t2_corr", best_corr, 30);
    chk("t2_stream", stream_err, 0);
    // abort during STREAM of hypothesis index 2
    @(negedge clk);
    base = rst_cnt;
    num_hyp = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !(rst_cnt - base == 3 && mem_rd_en); i++) @(negedge clk);
    chk("t3_reached", rst_cnt - base, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    chk("t3_creset", corr_reset, 1);
    chk("t3_rden", mem_rd_en, 0);
    chk("t3_rv", result_valid, 0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk("t3_nodone", saw_done, 0);
    corr_vals[0] = 16'h0055;
    sweep(1, 1, 0, 0, 0, 100, cyc, ok);
    chk("t3_rerun", ok, 1);
    chk("t3_cycles", cyc, 17);
    chk("t3_corr", best_corr, 16'h0055);
    chk("t3_rv", result_valid, 1);
    @(negedge clk);
    // correlator that never answers for one hypothesis
    corr_vals[0] = 10; corr_vals[2] = 5;
    hang_mask = 16'h0002;
`ifdef SFO_SEARCH_TIMEOUT_EN
    sweep(3, 0, 0, 1, 0, 200, cyc, ok);
    chk("t4_done", ok, 1);
    chk("t4_cycles", cyc, 59);
    chk("t4_to", timeout_err, 1);
    chk("t4_index", best_index, 0);
    chk("t4_corr", best_corr, 10);
    chk("t4_rv", result_valid, 1);
    @(negedge clk);
    hang_mask = 16'h0001;
    corr_vals[1] = 7;
    sweep(2, 0, 0, 1, 0, 200, cyc, ok);
    chk("t4b_done", ok, 1);
    chk("t4b_cycles", cyc, 43);
    chk("t4b_index", best_index, 1);
    chk("t4b_corr", best_corr, 7);
    chk("t4b_to", timeout_err, 1);
    @(negedge clk);
`else
    sweep(3, 0, 0, 1, 0, 150, cyc, ok);
    chk("t4_hang", ok, 0);
    chk("t4_busy", busy, 1);
    chk("t4_to", timeout_err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort", busy, 0);
    @(negedge clk);
`endif
    // empty sweep
    sweep(0, 0, 0, 0, 0, 10, cyc, ok);
    chk("t5_done", ok, 1);
    chk("t5_cycles", cyc, 1);
    chk("t5_rv", result_valid, 0);
    chk("t5_to", timeout_err, 0);
    @(negedge clk);
    chk("t5_pulse", done, 0);
    // asynchronous reset while waiting on the correlator
    hang_mask = 16'h0001;
    base = rst_cnt;
    num_hyp = 1; s_int = 9; s_frac = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_sfo", corr_sfo_int_part, 9);
    #2 resetn = 1'b0;
    #1;
    chk("t6_r_busy", busy, 0);
    chk("t6_r_best", best_corr, 0);
    chk("t6_r_sfo", corr_sfo_int_part, 0);
    chk("t6_r_rv", result_valid, 0);
    chk("t6_r_upd", corr_update, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
